vs_xform_engine: RTL

Parametrised 4x4 fixed-point vertex transform engine, the next-generation vertex-shader datapath. Holds a host-loaded 4x4 matrix, fetches each vertex's x/y/z from the vertex buffer, and multiplies the homogeneous vector (x, y, z, 1.0) with one serial MAC. It streams x', y', z', w' to the downstream stage with saturation and backpressure. It replaces the hard-coded per-stage transform sequence with a single reusable matrix stage, which can be chained or re-run per pass.

---
 rtl/vs_xform_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vs_xform_engine.sv
// 4x4 fixed-point matrix * (x,y,z,1) vertex transform with one serial MAC and saturating output.
// Latency: 3 fetch + 1 fetch-wait + 16 MAC + 4 emit cycles per vertex, then one DONE cycle.
// Backpressure: out_ready stalls EMIT; result, comp and index hold until each component is accepted.
module vs_xform_engine #(
   parameter int FIXED_WIDTH = 16,
   parameter int FRAC_BITS   = 8,
   parameter int INDEX_BIT   = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   mat_wr,
   input  logic [3:0]             mat_addr,
   input  logic [FIXED_WIDTH-1:0] mat_data,
   input  logic                   start,
   input  logic [INDEX_BIT-1:0]   num_vertex,
   output logic                   busy,
   output logic                   done,
   output logic                   sat_flag,
   output logic                   vb_rd_en,
   output logic [INDEX_BIT+1:0]   vb_rd_addr,
   input  logic [FIXED_WIDTH-1:0] vb_rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INDEX_BIT-1:0]   out_index,
   output logic [1:0]             out_comp,
   output logic [FIXED_WIDTH-1:0] out_data
);

   localparam int ACC_W = 2*FIXED_WIDTH + 2;
   localparam logic signed [FIXED_WIDTH-1:0] ONE     = FIXED_WIDTH'(2**FRAC_BITS);
   localparam logic signed [ACC_W-1:0]       MAX_ACC = ACC_W'((2**(FIXED_WIDTH-1)) - 1);
   localparam logic signed [ACC_W-1:0]       MIN_ACC = ACC_W'(-(2**(FIXED_WIDTH-1)));
   localparam logic signed [FIXED_WIDTH-1:0] MAX_OUT = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
   localparam logic signed [FIXED_WIDTH-1:0] MIN_OUT = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, FETCH, FETCH_WAIT, MAC, EMIT, DONE} state_t;

   state_t                         state, state_nxt;
   logic [3:0]                     cnt;
   logic [INDEX_BIT-1:0]           idx, count;
   logic [1:0]                     ocomp;
   logic [INDEX_BIT+1:0]           rd_addr_q;
   logic signed [FIXED_WIDTH-1:0]  mat [16];
   logic signed [FIXED_WIDTH-1:0]  v   [3];
   logic signed [FIXED_WIDTH-1:0]  res [4];
   logic signed [ACC_W-1:0]        acc;

   logic                           last_vertex;
   logic signed [FIXED_WIDTH-1:0]  m_sel, v_sel;
   logic signed [2*FIXED_WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]        sum, shifted;
   logic signed [FIXED_WIDTH-1:0]  sat_val;
   logic                           sat_hit;

   assign last_vertex = ({1'b0, idx} + 1'b1) == {1'b0, count};

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (start) state_nxt = (num_vertex == '0) ? DONE : FETCH;
         FETCH:      if (cnt == 4'd2) state_nxt = FETCH_WAIT;
         FETCH_WAIT: state_nxt = MAC;
         MAC:        if (cnt == 4'd15) state_nxt = EMIT;
         EMIT:       if (out_ready && ocomp == 2'd3) state_nxt = last_vertex ? DONE : FETCH;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Matrix is deliberately outside reset so it survives across runs and resets.
   always_ff @(posedge clk) begin
      if (state == IDLE && mat_wr) mat[mat_addr] <= mat_data;
   end

   // cnt = {row, col} during MAC, so it indexes the row-major matrix directly.
   always_comb begin
      m_sel = mat[cnt];
      case (cnt[1:0])
         2'd0:    v_sel = v[0];
         2'd1:    v_sel = v[1];
         2'd2:    v_sel = v[2];
         default: v_sel = ONE;
      endcase
      prod    = m_sel * v_sel;
      sum     = ((cnt[1:0] == 2'd0) ? '0 : acc) + {{2{prod[2*FIXED_WIDTH-1]}}, prod};
      shifted = sum >>> FRAC_BITS;
      sat_hit = 1'b0;
      sat_val = shifted[FIXED_WIDTH-1:0];
      if (shifted > MAX_ACC) begin
         sat_val = MAX_OUT;
         sat_hit = 1'b1;
      end else if (shifted < MIN_ACC) begin
         sat_val = MIN_OUT;
         sat_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt       <= '0;
         idx       <= '0;
         count     <= '0;
         ocomp     <= '0;
         rd_addr_q <= '0;
         acc       <= '0;
         sat_flag  <= 1'b0;
         for (int i = 0; i < 3; i++) v[i] <= '0;
         for (int i = 0; i < 4; i++) res[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  count    <= num_vertex;
                  idx      <= '0;
                  sat_flag <= 1'b0;
                  cnt      <= '0;
                  ocomp    <= '0;
               end
            end
            FETCH: begin
               rd_addr_q <= {idx, cnt[1:0]};
               // read data lags the strobe by one cycle
               if (cnt != 4'd0) v[cnt[1:0] - 2'd1] <= vb_rd_data;
               cnt <= (cnt == 4'd2) ? 4'd0 : cnt + 4'd1;
            end
            FETCH_WAIT: begin
               v[2] <= vb_rd_data;
               cnt  <= '0;
            end
            MAC: begin
               acc <= sum;
               cnt <= cnt + 4'd1;
               if (cnt[1:0] == 2'd3) begin
                  res[cnt[3:2]] <= sat_val;
                  if (sat_hit) sat_flag <= 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  ocomp <= ocomp + 2'd1;
                  if (ocomp == 2'd3 && !last_vertex) idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign vb_rd_en   = (state == FETCH);
   assign vb_rd_addr = vb_rd_en ? {idx, cnt[1:0]} : rd_addr_q;
   assign out_valid  = (state == EMIT);
   assign out_index  = idx;
   assign out_comp   = ocomp;
   assign out_data   = res[ocomp];

endmodule
